// File: rtl/uart_rx_core_if.sv
// Receive-side handshake bundle between the UART receiver and the CPU register block.
// Latency: none (plain wires).
// Backpressure: the consumer drains each byte with a one-cycle rx_ack pulse.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_overrun;
    logic       rx_busy;
    logic       rx_ack;

    // Receiver side: produces the byte and status, observes the acknowledge.
    modport master (
        output rx_data,
        output rx_avail,
        output rx_error,
        output rx_overrun,
        output rx_busy,
        input  rx_ack
    );

    // Consumer side: reads the byte and status, returns the acknowledge.
    modport slave (
        input  rx_data,
        input  rx_avail,
        input  rx_error,
        input  rx_overrun,
        input  rx_busy,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling, avail/ack byte handshake, framing and overrun flags.
// Latency: rx_avail rises 2 sync + 16*9+9 tick-samples + 1 cycle after the start edge.
// Backpressure: none on the line; an unacknowledged byte is overwritten and rx_overrun is raised.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority voting over samples 7, 8 and 9.
module uart_rx_core #(
    parameter int freq_hz = 27000000,
    parameter int baud    = 115200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          uart_rxd,
    uart_rx_core_if.master rx
);

    localparam int OS_RAW = (freq_hz + baud * 8) / (baud * 16);
    localparam int OS_DIV = (OS_RAW < 1) ? 1 : OS_RAW;
    localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(OS_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sync1;
    logic          rxd_s;
    logic [CW-1:0] tick_cnt;
    logic          tick;

    state_t        state, state_n;
    logic [3:0]    sc, sc_n;
    logic [2:0]    bi, bi_n;
    logic [7:0]    shreg, shreg_n;
    logic          s8, s8_n;
    logic          bit_val;
    logic [7:0]    data_q, data_n;
    logic          avail_q, avail_n;
    logic          err_q, err_n;
    logic          ovr_q, ovr_n;
    logic          busy_q, busy_n;

`ifdef UART_RX_MAJORITY_EN
    logic          s7, s7_n;

    // 2-of-3 vote over samples 7, 8 and the live sample at 9.
    assign bit_val = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
`else
    // Single mid-bit sample taken at 8, acted on at 9.
    assign bit_val = s8;
`endif

    // Two-flop synchroniser; everything downstream looks only at rxd_s.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxd_s <= sync1;
        end
    end

    assign tick = (tick_cnt == '0);

    // Free-running oversample tick divider, never realigned to frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= RELOAD;
        end else if (tick) begin
            tick_cnt <= RELOAD;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    // Frame state and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sc      <= 4'd0;
            bi      <= 3'd0;
            shreg   <= 8'h00;
            s8      <= 1'b1;
            data_q  <= 8'h00;
            avail_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            s7      <= 1'b1;
`endif
        end else begin
            state   <= state_n;
            sc      <= sc_n;
            bi      <= bi_n;
            shreg   <= shreg_n;
            s8      <= s8_n;
            data_q  <= data_n;
            avail_q <= avail_n;
            err_q   <= err_n;
            ovr_q   <= ovr_n;
            busy_q  <= busy_n;
`ifdef UART_RX_MAJORITY_EN
            s7      <= s7_n;
`endif
        end
    end

    // Next-state, sampling and handshake; frame completion overrides a same-cycle ack.
    always_comb begin
        state_n = state;
        sc_n    = sc;
        bi_n    = bi;
        shreg_n = shreg;
        s8_n    = s8;
        data_n  = data_q;
        avail_n = avail_q;
        err_n   = err_q;
        ovr_n   = ovr_q;
`ifdef UART_RX_MAJORITY_EN
        s7_n    = s7;
`endif

        if (rx.rx_ack) begin
            avail_n = 1'b0;
            err_n   = 1'b0;
            ovr_n   = 1'b0;
        end

        if (tick) begin
            if (state != IDLE) begin
                sc_n = sc + 4'd1;
                if (sc == 4'd8) begin
                    s8_n = rxd_s;
                end
`ifdef UART_RX_MAJORITY_EN
                if (sc == 4'd7) begin
                    s7_n = rxd_s;
                end
`endif
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_n = START;
                        sc_n    = 4'd1;
                    end
                end
                START: begin
                    if (sc == 4'd9 && bit_val) begin
                        state_n = IDLE;
                    end else if (sc == 4'd15) begin
                        state_n = DATA;
                        bi_n    = 3'd0;
                    end
                end
                DATA: begin
                    if (sc == 4'd9) begin
                        shreg_n[bi] = bit_val;
                    end
                    if (sc == 4'd15) begin
                        if (bi == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            bi_n = bi + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (sc == 4'd9) begin
                        state_n = IDLE;
                        if (bit_val) begin
                            data_n  = shreg;
                            avail_n = 1'b1;
                            ovr_n   = (ovr_q | avail_q) & ~rx.rx_ack;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n != IDLE);
    end

    assign rx.rx_data    = data_q;
    assign rx.rx_avail   = avail_q;
    assign rx.rx_error   = err_q;
    assign rx.rx_overrun = ovr_q;
    assign rx.rx_busy    = busy_q;

endmodule
